mips_multicycle: RTL and testbench

- Parametrised multi-cycle successor to the single-cycle MIPS top.
- Executes the same subset (R-type add/sub/and/or/slt/jr, lw, sw, beq, bne, addi, j, jal) through a FETCH/DECODE/EXEC/MEM/WB state machine.
- Contains its own 32x32 register file and ALU, and uses one unified memory port with a req/ready handshake, so memory may insert wait states.
- Adds a retired-instruction counter and a halt/error state.

---
 rtl/mips_multicycle.sv | 191 +++++++++++++++++++
 tb/tb_mips_multicycle.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle.sv
// Multi-cycle MIPS subset core sharing one req/ready memory port for fetch and data.
// j/jal 2, beq/bne/jr 3, R/addi/sw 4, lw 5 cycles; every memory wait state stretches FETCH or MEM by one.
module mips_multicycle #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clock,
  input  logic             reset,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ready,
  output logic [31:0]      pc,
  output logic [CNT_W-1:0] retired,
  output logic             halted
);

  localparam logic [5:0] OP_R   = 6'h00, OP_J  = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A, FN_JR = 6'h08;

  // S_START keeps mem_req low during reset and the cycle reset is released.
  typedef enum logic [2:0] {S_START, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
  state_t state, state_nxt;

  logic [31:0] ir, a, b, imm, alu_out, mdr, alu_res, pc_nxt, rf_wdata;
  logic [31:0] regs [32];
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, rf_waddr;
  logic        legal, pc_we, ir_we, alu_we, mdr_we, rf_we, retire, is_mem;

  assign op     = ir[31:26];
  assign rs     = ir[25:21];
  assign rt     = ir[20:16];
  assign rd     = ir[15:11];
  assign funct  = ir[5:0];
  assign is_mem = (op == OP_LW) || (op == OP_SW);

  always_comb begin
    legal = 1'b0;
    case (op)
      OP_R:                                          legal = funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_JR};
      OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_LW, OP_SW: legal = 1'b1;
      default:                                       legal = 1'b0;
    endcase
  end

  always_comb begin
    alu_res = a + imm;
    if (op == OP_R) begin
      case (funct)
        FN_SUB:  alu_res = a - b;
        FN_AND:  alu_res = a & b;
        FN_OR:   alu_res = a | b;
        FN_SLT:  alu_res = {31'd0, $signed(a) < $signed(b)};
        default: alu_res = a + b;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_START;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    halted    = 1'b0;
    pc_we     = 1'b0;
    pc_nxt    = pc;
    ir_we     = 1'b0;
    alu_we    = 1'b0;
    mdr_we    = 1'b0;
    rf_we     = 1'b0;
    rf_waddr  = rt;
    rf_wdata  = alu_out;
    retire    = 1'b0;
    case (state)
      S_START: state_nxt = S_FETCH;
      S_FETCH: begin
        if (pc[1:0] != 2'b00) begin
          state_nxt = S_HALT;
        end else begin
          mem_req  = 1'b1;
          mem_addr = pc;
          if (mem_ready) begin
            ir_we     = 1'b1;
            pc_we     = 1'b1;
            pc_nxt    = pc + 32'd4;
            state_nxt = S_DECODE;
          end
        end
      end
      S_DECODE: begin
        if (op == OP_J || op == OP_JAL) begin
          pc_we     = 1'b1;
          pc_nxt    = {pc[31:28], ir[25:0], 2'b00};
          rf_we     = (op == OP_JAL);
          rf_waddr  = 5'd31;
          rf_wdata  = pc;
          retire    = 1'b1;
          state_nxt = S_FETCH;
        end else if (!legal) begin
          state_nxt = S_HALT;
        end else begin
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (op == OP_R && funct == FN_JR) begin
          pc_we     = 1'b1;
          pc_nxt    = a;
          retire    = 1'b1;
          state_nxt = S_FETCH;
        end else if (op == OP_BEQ || op == OP_BNE) begin
          // pc already points past the branch, so the offset is relative to PC+4.
          if ((a == b) == (op == OP_BEQ)) begin
            pc_we  = 1'b1;
            pc_nxt = pc + {imm[29:0], 2'b00};
          end
          retire    = 1'b1;
          state_nxt = S_FETCH;
        end else begin
          alu_we = 1'b1;
          if (is_mem && alu_res[1:0] != 2'b00) state_nxt = S_HALT;
          else if (is_mem)                     state_nxt = S_MEM;
          else                                 state_nxt = S_WB;
        end
      end
      S_MEM: begin
        mem_req   = 1'b1;
        mem_addr  = alu_out;
        mem_we    = (op == OP_SW);
        mem_wdata = (op == OP_SW) ? b : '0;
        if (mem_ready) begin
          if (op == OP_SW) begin
            retire    = 1'b1;
            state_nxt = S_FETCH;
          end else begin
            mdr_we    = 1'b1;
            state_nxt = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we     = 1'b1;
        rf_waddr  = (op == OP_R) ? rd : rt;
        rf_wdata  = (op == OP_LW) ? mdr : alu_out;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_HALT:  halted = 1'b1;
      default: state_nxt = S_HALT;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc      <= RESET_PC;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      imm     <= '0;
      alu_out <= '0;
      mdr     <= '0;
      retired <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      if (pc_we)  pc      <= pc_nxt;
      if (ir_we)  ir      <= mem_rdata;
      if (alu_we) alu_out <= alu_res;
      if (mdr_we) mdr     <= mem_rdata;
      if (state == S_DECODE) begin
        a   <= regs[rs];
        b   <= regs[rt];
        imm <= {{16{ir[15]}}, ir[15:0]};
      end
      // R0 is never written, so it keeps its reset value of zero.
      if (rf_we && rf_waddr != 5'd0) regs[rf_waddr] <= rf_wdata;
      if (retire) retired <= retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mips_multicycle.sv
// Bench for mips_multicycle: lock-step against an instruction-level model with a wait-state memory responder.
module tb_mips_multicycle;
  localparam logic [31:0] RPC = 32'h100;
  localparam logic [31:0] ILL = 32'hFC00_0000;

  logic        clock = 1'b0, reset = 1'b0;
  logic        mem_req, mem_we, halted;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr, mem_wdata, pc, retired;
  logic [31:0] mem_rdata = '0;

  mips_multicycle #(.RESET_PC(RPC), .CNT_W(32)) dut (
    .clock(clock), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .pc(pc),
    .retired(retired), .halted(halted));

  always #5 clock = ~clock;

  logic [31:0] mem [256];
  logic [31:0] mmem [256];
  logic [31:0] mreg [32];
  logic [31:0] m_pc, m_ret, pp;
  int          waits = 0, wait_cnt = -1, wr_cnt = 0, n_cmp = 0, n_bad = 0;
  bit          pend = 0, first = 0;
  logic        pend_we;
  logic [31:0] pend_addr, pend_data;

  // Memory responder: raises ready after 'waits' idle cycles; writes commit only once accepted.
  always @(negedge clock) begin
    if (!reset) begin
      mem_ready = 1'b0;
      wait_cnt  = -1;
      pend      = 0;
    end else begin
      if (pend) begin
        if (pend_we) begin
          mem[pend_addr[9:2]] = pend_data;
          wr_cnt++;
        end
        pend      = 0;
        mem_ready = 1'b0;
      end
      if (mem_req) begin
        if (wait_cnt < 0) wait_cnt = waits;
        if (wait_cnt == 0) begin
          mem_ready = 1'b1;
          mem_rdata = mem[mem_addr[9:2]];
          pend      = 1;
          pend_we   = mem_we;
          pend_addr = mem_addr;
          pend_data = mem_wdata;
          wait_cnt  = -1;
        end else begin
          wait_cnt--;
        end
      end
    end
  end

  function automatic logic [31:0] fillw(input int i);
    return 32'hA400_0000 | 32'(i);
  endfunction
  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
  endfunction
  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction
  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [31:0] tgt);
    return {op, tgt[27:2]};
  endfunction
  function automatic int mem_diffs();
    int d = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== mmem[i]) d++;
    return d;
  endfunction

  task automatic emit(input logic [31:0] w);
    mem[pp[9:2]] = w;
    pp = pp + 32'd4;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = fillw(i);
    pp = RPC;
  endtask

  task automatic start(input int w);
    waits = w;
    mmem  = mem;
    for (int i = 0; i < 32; i++) mreg[i] = '0;
    m_pc  = RPC;
    m_ret = '0;
    first = 1;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  // Architectural model: one instruction, returning its expected cycle count.
  task automatic model_step(output int cyc, output bit halt);
    logic [31:0] ins, va, vb, im, ea;
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd;
    cyc = 0;
    halt = 0;
    if (m_pc[1:0] != 2'b00) begin
      halt = 1;
      return;
    end
    ins = mmem[m_pc[9:2]];
    m_pc = m_pc + 32'd4;
    op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11]; fn = ins[5:0];
    va = mreg[rs]; vb = mreg[rt]; im = {{16{ins[15]}}, ins[15:0]};
    case (op)
      6'h00: begin
        cyc = 4;
        case (fn)
          6'h20: mreg[rd] = va + vb;
          6'h22: mreg[rd] = va - vb;
          6'h24: mreg[rd] = va & vb;
          6'h25: mreg[rd] = va | vb;
          6'h2A: mreg[rd] = ($signed(va) < $signed(vb)) ? 32'd1 : 32'd0;
          6'h08: begin m_pc = va; cyc = 3; end
          default: halt = 1;
        endcase
      end
      6'h02: begin m_pc = {m_pc[31:28], ins[25:0], 2'b00}; cyc = 2; end
      6'h03: begin mreg[31] = m_pc; m_pc = {m_pc[31:28], ins[25:0], 2'b00}; cyc = 2; end
      6'h04: begin if (va == vb) m_pc = m_pc + (im << 2); cyc = 3; end
      6'h05: begin if (va != vb) m_pc = m_pc + (im << 2); cyc = 3; end
      6'h08: begin mreg[rt] = va + im; cyc = 4; end
      6'h23: begin
        ea = va + im;
        if (ea[1:0] != 2'b00) halt = 1;
        else begin mreg[rt] = mmem[ea[9:2]]; cyc = 5 + waits; end
      end
      6'h2B: begin
        ea = va + im;
        if (ea[1:0] != 2'b00) halt = 1;
        else begin mmem[ea[9:2]] = vb; cyc = 4 + waits; end
      end
      default: halt = 1;
    endcase
    mreg[0] = '0;
    cyc = cyc + waits;
    if (!halt) m_ret = m_ret + 32'd1;
  endtask

  // Advances model and DUT by one instruction; the first after reset includes the start-up cycle.
  task automatic exec_one(output int ec, output bit eh, output int gc, output bit to);
    logic [31:0] r0;
    model_step(ec, eh);
    if (first) ec++;
    first = 0;
    gc = 0;
    to = 0;
    if (eh) return;
    r0 = retired;
    while (retired === r0 && !halted && !to) begin
      @(negedge clock);
      gc++;
      if (gc > 300) to = 1;
    end
  endtask

  task automatic wait_halt(output bit to);
    int n = 0;
    to = 0;
    while (!halted && !to) begin
      @(negedge clock);
      n++;
      if (n > 60) to = 1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'd0 || mem_wdata !== 32'd0 ||
        halted !== 1'b0 || retired !== 32'd0 || pc !== RPC) begin
      n_bad++;
      $display("FAIL reset_state: req=%b we=%b addr=%h wd=%h halt=%b ret=%0d pc=%h, want 0 0 0 0 0 0 %h",
               mem_req, mem_we, mem_addr, mem_wdata, halted, retired, pc, RPC);
    end
    start(0);
    #1;
    n_cmp++;
    if (mem_req !== 1'b0) begin
      n_bad++;
      $display("FAIL req_before_edge: mem_req=%b, want 0", mem_req);
    end
    @(negedge clock);
    n_cmp++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== RPC || pc !== RPC || retired !== 32'd0) begin
      n_bad++;
      $display("FAIL first_fetch: req=%b we=%b addr=%h pc=%h ret=%0d, want 1 0 %h %h 0",
               mem_req, mem_we, mem_addr, pc, retired, RPC, RPC);
    end
  endtask

  task automatic test_alu_waits();
    int ec, gc; bit eh, to;
    do_reset();
    emit(enc_i(6'h08, 0, 1, 5));
    emit(enc_i(6'h08, 0, 2, -3));
    emit(enc_r(1, 2, 3, 6'h20));
    emit(enc_r(2, 1, 4, 6'h2A));
    emit(enc_i(6'h2B, 0, 3, 32'h200));
    emit(enc_i(6'h2B, 0, 4, 32'h204));
    emit(ILL);
    start(2);
    for (int k = 0; k < 64; k++) begin
      exec_one(ec, eh, gc, to);
      if (eh) break;
      n_cmp++;
      if (to || gc !== ec || pc !== m_pc || retired !== m_ret) begin
        n_bad++;
        $display("FAIL alu_step%0d: cyc=%0d pc=%h ret=%0d, want cyc=%0d pc=%h ret=%0d", k, gc, pc, retired, ec, m_pc, m_ret);
      end
    end
    wait_halt(to);
    n_cmp++;
    if (to || mem[128] !== 32'd2 || mem[129] !== 32'd1 || retired !== 32'd6 || mem_diffs() != 0) begin
      n_bad++;
      $display("FAIL alu_result: R3=%h R4=%h ret=%0d diffs=%0d, want 2 1 6 0", mem[128], mem[129], retired, mem_diffs());
    end
  endtask

  task automatic test_memory();
    int ec, gc, w0; bit eh, to;
    do_reset();
    emit(enc_i(6'h08, 0, 1, 32'h40));
    emit(enc_i(6'h2B, 1, 1, 0));
    emit(enc_i(6'h23, 1, 5, 0));
    emit(enc_i(6'h2B, 0, 5, 32'h200));
    emit(ILL);
    w0 = wr_cnt;
    start(0);
    for (int k = 0; k < 64; k++) begin
      exec_one(ec, eh, gc, to);
      if (eh) break;
      n_cmp++;
      if (to || gc !== ec || pc !== m_pc || retired !== m_ret) begin
        n_bad++;
        $display("FAIL mem_step%0d: cyc=%0d pc=%h ret=%0d, want cyc=%0d pc=%h ret=%0d", k, gc, pc, retired, ec, m_pc, m_ret);
      end
    end
    wait_halt(to);
    n_cmp++;
    if (to || mem[16] !== 32'h40 || mem[128] !== 32'h40 || wr_cnt - w0 !== 2 || mem_diffs() != 0) begin
      n_bad++;
      $display("FAIL mem_result: [0x40]=%h R5=%h writes=%0d diffs=%0d, want 40 40 2 0", mem[16], mem[128], wr_cnt - w0, mem_diffs());
    end
  endtask

  task automatic test_control_flow();
    int ec, gc; bit eh, to;
    do_reset();
    emit(enc_i(6'h04, 0, 0, 2));
    emit(enc_i(6'h08, 0, 9, 1));
    emit(enc_i(6'h08, 0, 9, 2));
    emit(enc_j(6'h03, 32'h300));
    emit(enc_i(6'h05, 0, 0, 5));
    emit(enc_i(6'h2B, 0, 31, 32'h200));
    emit(enc_i(6'h2B, 0, 9, 32'h204));
    emit(enc_i(6'h2B, 0, 10, 32'h208));
    emit(ILL);
    pp = 32'h300;
    emit(enc_i(6'h08, 0, 10, 77));
    emit(enc_r(31, 0, 0, 6'h08));
    start(1);
    for (int k = 0; k < 64; k++) begin
      exec_one(ec, eh, gc, to);
      if (eh) break;
      n_cmp++;
      if (to || gc !== ec || pc !== m_pc || retired !== m_ret) begin
        n_bad++;
        $display("FAIL ctl_step%0d: cyc=%0d pc=%h ret=%0d, want cyc=%0d pc=%h ret=%0d", k, gc, pc, retired, ec, m_pc, m_ret);
      end
    end
    wait_halt(to);
    n_cmp++;
    if (to || mem[128] !== 32'h110 || mem[129] !== 32'd0 || mem[130] !== 32'd77 || mem_diffs() != 0) begin
      n_bad++;
      $display("FAIL ctl_result: R31=%h R9=%h R10=%0d diffs=%0d, want 110 0 77 0", mem[128], mem[129], mem[130], mem_diffs());
    end
  endtask

  task automatic test_halt();
    int ec, gc; bit eh, to;
    logic [31:0] hp, hr;
    for (int c = 0; c < 4; c++) begin
      do_reset();
      case (c)
        0: begin emit(enc_i(6'h08, 0, 1, 3));      emit(ILL); end
        1: begin emit(enc_i(6'h08, 0, 1, 32'h41)); emit(enc_i(6'h23, 1, 2, 0)); end
        2: begin emit(enc_i(6'h08, 0, 1, 32'h102)); emit(enc_r(1, 0, 0, 6'h08)); end
        default: begin emit(enc_i(6'h08, 0, 1, 1)); emit(enc_r(1, 1, 2, 6'h21)); end
      endcase
      start(int'($urandom_range(0, 1)));
      for (int k = 0; k < 8; k++) begin
        exec_one(ec, eh, gc, to);
        if (eh) break;
        n_cmp++;
        if (to || gc !== ec || pc !== m_pc || retired !== m_ret) begin
          n_bad++;
          $display("FAIL halt%0d_step%0d: cyc=%0d pc=%h ret=%0d, want cyc=%0d pc=%h ret=%0d", c, k, gc, pc, retired, ec, m_pc, m_ret);
        end
      end
      wait_halt(to);
      hp = pc;
      hr = retired;
      n_cmp++;
      if (to || halted !== 1'b1 || mem_req !== 1'b0 || retired !== m_ret || pc !== m_pc) begin
        n_bad++;
        $display("FAIL halt%0d_state: halt=%b req=%b ret=%0d pc=%h, want 1 0 %0d %h", c, halted, mem_req, retired, pc, m_ret, m_pc);
      end
      repeat (5) @(negedge clock);
      n_cmp++;
      if (halted !== 1'b1 || mem_req !== 1'b0 || retired !== hr || pc !== hp) begin
        n_bad++;
        $display("FAIL halt%0d_frozen: halt=%b req=%b ret=%0d pc=%h, want 1 0 %0d %h", c, halted, mem_req, retired, pc, hr, hp);
      end
      reset = 1'b0;
      #1;
      n_cmp++;
      if (halted !== 1'b0 || pc !== RPC || retired !== 32'd0) begin
        n_bad++;
        $display("FAIL halt%0d_reset: halt=%b pc=%h ret=%0d, want 0 %h 0", c, halted, pc, retired, RPC);
      end
    end
  endtask

  task automatic test_edge();
    int ec, gc, w0, n; bit eh, to;
    do_reset();
    emit(enc_i(6'h08, 0, 0, 7));
    emit(enc_i(6'h2B, 0, 0, 32'h200));
    emit(enc_i(6'h08, 0, 2, 1));
    for (int i = 0; i < 31; i++) emit(enc_r(2, 2, 2, 6'h20));
    emit(enc_i(6'h08, 2, 1, -1));
    emit(enc_i(6'h08, 0, 4, 1));
    emit(enc_r(1, 4, 3, 6'h20));
    emit(enc_i(6'h2B, 0, 3, 32'h204));
    emit(enc_i(6'h2B, 0, 1, 32'h208));
    emit(ILL);
    start(0);
    for (int k = 0; k < 64; k++) begin
      exec_one(ec, eh, gc, to);
      if (eh) break;
      n_cmp++;
      if (to || gc !== ec || pc !== m_pc || retired !== m_ret) begin
        n_bad++;
        $display("FAIL edge_step%0d: cyc=%0d pc=%h ret=%0d, want cyc=%0d pc=%h ret=%0d", k, gc, pc, retired, ec, m_pc, m_ret);
      end
    end
    wait_halt(to);
    n_cmp++;
    if (to || mem[128] !== 32'd0 || mem[129] !== 32'h8000_0000 || mem[130] !== 32'h7FFF_FFFF || mem_diffs() != 0) begin
      n_bad++;
      $display("FAIL edge_result: R0=%h sum=%h max=%h diffs=%0d, want 0 80000000 7fffffff 0", mem[128], mem[129], mem[130], mem_diffs());
    end
    // Reset while a store is waiting for ready must abandon the write.
    do_reset();
    emit(enc_i(6'h08, 0, 1, 32'h55));
    emit(enc_i(6'h2B, 0, 1, 32'h20C));
    start(3);
    n = 0;
    while (!(mem_req === 1'b1 && mem_we === 1'b1) && n < 100) begin
      @(negedge clock);
      n++;
    end
    w0 = wr_cnt;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (n >= 100 || mem_req !== 1'b0 || mem_addr !== 32'd0) begin
      n_bad++;
      $display("FAIL sw_reset_drop: waited=%0d req=%b addr=%h, want <100 0 0", n, mem_req, mem_addr);
    end
    repeat (6) @(negedge clock);
    n_cmp++;
    if (wr_cnt !== w0 || mem[131] !== fillw(131)) begin
      n_bad++;
      $display("FAIL sw_reset_nowrite: writes=%0d word=%h, want %0d %h", wr_cnt, mem[131], w0, fillw(131));
    end
  endtask

  task automatic test_random();
    int ec, gc, kind; bit eh, to;
    logic [5:0] fns [5];
    fns[0] = 6'h20; fns[1] = 6'h22; fns[2] = 6'h24; fns[3] = 6'h25; fns[4] = 6'h2A;
    for (int it = 0; it < 8; it++) begin
      do_reset();
      for (int i = 0; i < 14; i++) begin
        kind = int'($urandom_range(0, 9));
        if (kind < 4)
          emit(enc_i(6'h08, int'($urandom_range(0, 7)), int'($urandom_range(1, 7)), int'($urandom_range(0, 65535))));
        else if (kind < 8)
          emit(enc_r(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), fns[$urandom_range(0, 4)]));
        else if (kind == 8)
          emit(enc_i($urandom_range(0, 1) ? 6'h04 : 6'h05, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1));
        else
          emit(enc_i($urandom_range(0, 1) ? 6'h2B : 6'h23, 0, int'($urandom_range(1, 7)), 32'h200 + 4 * $urandom_range(0, 7)));
      end
      for (int r = 1; r < 8; r++) emit(enc_i(6'h2B, 0, r, 32'h220 + 4 * r));
      emit(ILL);
      start(int'($urandom_range(0, 2)));
      for (int k = 0; k < 64; k++) begin
        exec_one(ec, eh, gc, to);
        if (eh) break;
        n_cmp++;
        if (to || gc !== ec || pc !== m_pc || retired !== m_ret) begin
          n_bad++;
          $display("FAIL rnd%0d_step%0d: cyc=%0d pc=%h ret=%0d, want cyc=%0d pc=%h ret=%0d", it, k, gc, pc, retired, ec, m_pc, m_ret);
        end
      end
      wait_halt(to);
      n_cmp++;
      if (to || retired !== m_ret || pc !== m_pc || mem_diffs() != 0) begin
        n_bad++;
        $display("FAIL rnd%0d_result: ret=%0d pc=%h diffs=%0d, want %0d %h 0", it, retired, pc, mem_diffs(), m_ret, m_pc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu_waits();
    test_memory();
    test_control_flow();
    test_halt();
    test_edge();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
